// File: rtl/wb_ram_slave.sv
// Wishbone classic slave backed by a word-addressed single-port RAM.
// Byte-lane writes, registered ack/read data, configurable wait states between accept and ack.
module wb_ram_slave #(
  parameter int    XLEN        = 32,
  parameter int    DEPTH       = 4096,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [XLEN/8-1:0] i_sel,
  input  logic [XLEN-1:0]   i_adr,
  input  logic [XLEN-1:0]   i_wdat,
  output logic [XLEN-1:0]   o_rdat,
  output logic              o_ack
);

  localparam int LANES = XLEN / 8;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [XLEN-1:0]  r_mem [DEPTH];

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_next;
  logic             r_ack;
  logic [XLEN-1:0]  r_rdat;

  logic             r_we;
  logic [LANES-1:0] r_sel;
  logic [AW-1:0]    r_idx;
  logic [XLEN-1:0]  r_wdat;

  logic             w_accept;
  logic             w_go_resp;
  logic             w_we;
  logic [LANES-1:0] w_sel;
  logic [AW-1:0]    w_idx;
  logic [XLEN-1:0]  w_wdat;
  logic             w_unused_adr;

  assign w_accept     = (r_state == S_IDLE) && i_cyc && i_stb;
  assign w_unused_adr = ^{i_adr[1:0], i_adr[XLEN-1:AW+2]};

  // With zero wait states the commit happens on the accept edge, so use the live bus fields.
  assign w_we   = (r_state == S_IDLE) ? i_we           : r_we;
  assign w_sel  = (r_state == S_IDLE) ? i_sel          : r_sel;
  assign w_idx  = (r_state == S_IDLE) ? i_adr[AW+1:2]  : r_idx;
  assign w_wdat = (r_state == S_IDLE) ? i_wdat         : r_wdat;

  assign w_go_resp = rst_n && (w_state_next == S_RESP) && (r_state != S_RESP);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES == 0) begin
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = 8'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!i_cyc) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == 8'd0) begin
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_ack   <= 1'b0;
      r_rdat  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ack   <= w_go_resp;
      if (w_go_resp && !w_we) begin
        r_rdat <= r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we   <= i_we;
      r_sel  <= i_sel;
      r_idx  <= i_adr[AW+1:2];
      r_wdat <= i_wdat;
    end
  end

  // Memory has no reset; the write is qualified by rst_n through w_go_resp.
  always_ff @(posedge clk) begin
    if (w_go_resp && w_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_sel[i]) begin
          r_mem[w_idx][i*8 +: 8] <= w_wdat[i*8 +: 8];
        end
      end
    end
  end

  assign o_ack  = r_ack;
  assign o_rdat = r_rdat;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: instance 0 has no wait states, instance 1 has three; both DEPTH=16.
// Drivers push expected ack cycle and read data; a negedge monitor pops on every ack.
module tb_wb_ram_slave;

  typedef struct {
    int          dut;
    int          edge_n;
    logic [31:0] rdat;
  } exp_t;

  logic        clk;
  logic        rst_n [2];
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic [31:0] adr   [2];
  logic [31:0] wdat  [2];
  logic [31:0] rdat  [2];
  logic        ack   [2];

  exp_t        q[$];
  int          edge_cnt = 0;
  int          ack_cnt [2];
  logic [31:0] last_rd [2];
  int          n_pass  = 0;
  int          n_total = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      wb_ram_slave #(
        .XLEN(32), .DEPTH(16), .WAIT_STATES(gi * 3), .INIT_FILE("")
      ) u_dut (
        .clk(clk), .rst_n(rst_n[gi]),
        .i_cyc(cyc[gi]), .i_stb(stb[gi]), .i_we(we[gi]), .i_sel(sel[gi]),
        .i_adr(adr[gi]), .i_wdat(wdat[gi]),
        .o_rdat(rdat[gi]), .o_ack(ack[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack[d] === 1'b1) begin
        check("ack_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          check("ack_dut", 32'(d), 32'(e.dut));
          check("ack_cycle", 32'(edge_cnt), 32'(e.edge_n));
          check("rdat", rdat[d], e.rdat);
          $display("ack dut%0d cycle %0d rdat %h", d, edge_cnt, rdat[d]);
        end
        ack_cnt[d]++;
      end
    end
  end

  function automatic int ws(input int d);
    return d * 3;
  endfunction

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input int d, input bit w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] dt);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; wdat[d] = dt;
  endtask

  task automatic stop(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic wait_acks(input int d, input int n);
    int t = 0;
    while (ack_cnt[d] < n && t < 60) begin
      nstep();
      t++;
    end
    check("ack_arrival", 32'(ack_cnt[d]), 32'(n));
  endtask

  task automatic xfer(input int d, input bit w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] dt, input logic [31:0] rexp);
    logic [31:0] rd;
    int          n;
    nstep();
    start(d, w, s, a, dt);
    rd = w ? last_rd[d] : rexp;
    if (!w) last_rd[d] = rexp;
    q.push_back('{dut: d, edge_n: edge_cnt + 1 + ws(d), rdat: rd});
    n = ack_cnt[d] + 1;
    wait_acks(d, n);
    stop(d);
  endtask

  initial begin
    int base;
    int e0;

    // Reset held with a request pending
    for (int d = 0; d < 2; d++) begin
      ack_cnt[d] = 0;
      last_rd[d] = 32'h0;
      rst_n[d]   = 1'b0;
      start(d, 1'b0, 4'hF, 32'h0, 32'h0);
    end
    repeat (2) begin
      nstep();
      for (int d = 0; d < 2; d++) begin
        check("rst_ack", 32'(ack[d]), 32'd0);
        check("rst_rdat", rdat[d], 32'h0);
      end
    end
    for (int d = 0; d < 2; d++) begin
      stop(d);
      rst_n[d] = 1'b1;
    end

    // Zero wait states: full word, byte lanes, alias, empty-select write
    xfer(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0);
    xfer(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF);
    xfer(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0);
    xfer(0, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 32'h0);
    xfer(0, 1'b0, 4'h0, 32'h20, 32'h0, 32'h11BB33DD);
    xfer(0, 1'b1, 4'hF, 32'h40, 32'h00000005, 32'h0);
    xfer(0, 1'b0, 4'hF, 32'h00, 32'h0, 32'h00000005);
    xfer(0, 1'b1, 4'h0, 32'h10, 32'h00000000, 32'h0);
    xfer(0, 1'b0, 4'hF, 32'h13, 32'h0, 32'hDEADBEEF);

    // Three wait states: latency, then stb held across two back-to-back reads
    xfer(1, 1'b1, 4'hF, 32'h30, 32'h12345678, 32'h0);
    xfer(1, 1'b0, 4'hF, 32'h30, 32'h0, 32'h12345678);
    nstep();
    start(1, 1'b0, 4'hF, 32'h30, 32'h0);
    e0 = edge_cnt + 1;
    q.push_back('{dut: 1, edge_n: e0 + 3, rdat: 32'h12345678});
    q.push_back('{dut: 1, edge_n: e0 + 8, rdat: 32'h12345678});
    wait_acks(1, ack_cnt[1] + 2);
    stop(1);

    // Abort in WAIT: cyc dropped one cycle after accept
    nstep();
    start(1, 1'b1, 4'hF, 32'h30, 32'hFFFFFFFF);
    base = ack_cnt[1];
    nstep();
    cyc[1] = 1'b0;
    repeat (6) nstep();
    stop(1);
    check("abort_no_ack", 32'(ack_cnt[1]), 32'(base));
    xfer(1, 1'b0, 4'hF, 32'h30, 32'h0, 32'h12345678);

    // Reset while in WAIT: transfer dropped, no write
    xfer(1, 1'b1, 4'hF, 32'h08, 32'h0BADF00D, 32'h0);
    nstep();
    start(1, 1'b1, 4'hF, 32'h08, 32'h00000077);
    base = ack_cnt[1];
    nstep();
    rst_n[1] = 1'b0;
    nstep();
    check("rst_wait_ack", 32'(ack[1]), 32'd0);
    check("rst_wait_rdat", rdat[1], 32'h0);
    stop(1);
    rst_n[1]   = 1'b1;
    last_rd[1] = 32'h0;
    repeat (4) nstep();
    check("rst_no_ack", 32'(ack_cnt[1]), 32'(base));
    xfer(1, 1'b1, 4'h0, 32'h0C, 32'h0, 32'h0);
    xfer(1, 1'b0, 4'hF, 32'h08, 32'h0, 32'h0BADF00D);

    repeat (5) nstep();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
